alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue/sequencing block that drives the processor ALU (opcode, alu0, alu1) and consumes its aluout.
- Accepts one fetched SP instruction over a valid/ready handshake and reads source registers from the register file.
- Forms ALU operands, captures the ALU result, then performs register writeback or branch resolution.
- Sits between fetch and the register file / PC logic; one instruction in flight at a time.

Parameters:
- PC_W, 16, width of PC and branch target.
- HALT_ON_ILLEGAL, 0, when 1 an illegal opcode also sets halt.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- inst_valid  input  1  instruction word presented
- inst_ready  output  1  block can accept an instruction
- inst  input  32  instruction: opcode[29:25], dst[24:22], src0[21:19], src1[18:16], imm[15:0]
- inst_pc  input  PC_W  PC of presented instruction
- rf_raddr0  output  3  register file read address 0
- rf_raddr1  output  3  register file read address 1
- rf_rdata0  input  32  read data 0, valid one cycle after address (synchronous read)
- rf_rdata1  input  32  read data 1, same timing
- alu_opcode  output  5  to ALU opcode
- alu0  output  32  to ALU operand 0
- alu1  output  32  to ALU operand 1
- aluout  input  32  combinational ALU result
- rf_we  output  1  writeback strobe, one cycle
- rf_waddr  output  3  writeback register
- rf_wdata  output  32  writeback data
- br_taken  output  1  branch-taken strobe, one cycle
- br_target  output  PC_W  branch target, valid with br_taken
- illegal  output  1  illegal-opcode strobe, one cycle
- halt  output  1  sticky halt

Behaviour:
- Opcodes:
  - ADD 0, SUB 1, LSF 2, RSF 3, AND 4, OR 5, XOR 6, LHI 7.
  - JLT 16, JLE 17, JEQ 18, JNE 19, JIN 20, HLT 24.
  - All others, including LD 8 and ST 9, are illegal here.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- inst_ready = (state==IDLE) && !halt.
- Accept when inst_valid && inst_ready.
  - Latch inst and inst_pc.
  - Drive rf_raddr0 = src0 and rf_raddr1 = src1; for LHI, rf_raddr0 = dst.
  - Go to READ.
- READ:
  - Operand value per selected register: reg 0 -> 0; reg 1 -> sign-extended imm; else rf_rdata.
  - Register alu_opcode, alu0, alu1. Go to EXEC.
  - Arithmetic and logic ops: alu0 = src0 value, alu1 = src1 value.
  - LHI: alu0 = dst value, alu1 = imm zero-extended.
  - Jumps: compare src0 value against src1 value.
- EXEC: capture aluout into a result register; go to WB.
- WB (one cycle), then always return to IDLE:
  - ALU ops 0-7: rf_we=1, rf_waddr=dst, rf_wdata=result. Suppressed (rf_we=0) when dst is 0 or 1.
  - JLT/JLE/JEQ/JNE: if result==1, br_taken=1 and br_target=imm[PC_W-1:0]; also rf_we=1, rf_waddr=7, rf_wdata=zero-extended inst_pc. If not taken, no strobes.
  - JIN: always taken; br_target = src0 value[PC_W-1:0]; r7 <- inst_pc.
  - HLT: halt set; no writeback.
  - Illegal: illegal=1 for one cycle; no writeback or branch; halt set only if HALT_ON_ILLEGAL.
- Latency and throughput:
  - Accept edge at cycle 0; alu outputs valid in cycle 2; rf_we/br_taken high in cycle 3.
  - Earliest next accept is cycle 4: one instruction per 4 cycles.
  - The WB write lands before the next READ, so no hazard logic is needed.
- Between instructions, alu_opcode/alu0/alu1 hold their last values. rf_we, br_taken and illegal are 0 outside WB.
- Halt is sticky: inst_ready stays 0 until reset. inst_valid is ignored while halted.
- Reset (asserted low, any state, including mid-instruction):
  - State returns to IDLE immediately.
  - All outputs and registers clear to 0, including halt and br_target.
  - The in-flight instruction is dropped with no writeback.
  - inst_ready = 1 on the first cycle after deassertion.
- inst_valid while not ready is ignored; the source must hold it until accepted.

Test Plan:
- ADD r2=r3+r4, rf r3=5, r4=7 -> alu_opcode=0, alu0=5, alu1=7 in cycle 2; rf_we in cycle 3 with waddr=2, wdata=12; inst_ready low for cycles 1-3.
- SUB r5=r1-r0, imm=0xFFFE -> alu0=0xFFFFFFFE, alu1=0; rf_wdata=0xFFFFFFFE. Also ADD with dst=1 -> rf_we never asserts.
- LHI r6, imm=0x1234, rf r6=0xAAAA5678 -> alu0=0xAAAA5678, alu1=0x1234; rf_wdata=0x12345678.
- JEQ with r3=r4=9, imm=0x0040, inst_pc=0x0010 -> br_taken=1, br_target=0x0040, r7<-0x10. JNE on the same operands -> no br_taken and no rf_we.
- Opcode 8 -> illegal pulse and no rf_we, halt stays 0. Then HLT -> halt=1 and inst_ready=0 despite inst_valid; reset low -> halt=0, inst_ready=1.
- Reset asserted during EXEC of ADD r2 -> no rf_we at any point. Next accepted instruction completes normally with 4-cycle latency.

Source files
------------

// File: rtl/alu_issue.sv
// Single-issue sequencer driving the ALU. It accepts an instruction, reads the register file,
// executes, then writes back or resolves a branch. Four cycles per instruction.
module alu_issue #(
  parameter int PC_W            = 16,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] inst_pc,
  output logic [2:0]      rf_raddr0,
  output logic [2:0]      rf_raddr1,
  input  logic [31:0]     rf_rdata0,
  input  logic [31:0]     rf_rdata1,
  output logic [4:0]      alu_opcode,
  output logic [31:0]     alu0,
  output logic [31:0]     alu1,
  input  logic [31:0]     aluout,
  output logic            rf_we,
  output logic [2:0]      rf_waddr,
  output logic [31:0]     rf_wdata,
  output logic            br_taken,
  output logic [PC_W-1:0] br_target,
  output logic            illegal,
  output logic            halt
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  localparam logic [4:0] OP_LHI = 5'd7;
  localparam logic [4:0] OP_JLT = 5'd16;
  localparam logic [4:0] OP_JLE = 5'd17;
  localparam logic [4:0] OP_JEQ = 5'd18;
  localparam logic [4:0] OP_JNE = 5'd19;
  localparam logic [4:0] OP_JIN = 5'd20;
  localparam logic [4:0] OP_HLT = 5'd24;

  state_t            state_q, state_d;
  logic [29:0]       inst_q, inst_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [4:0]        opc_q, opc_d;
  logic [31:0]       alu0_q, alu0_d, alu1_q, alu1_d;
  logic              rf_we_q, rf_we_d;
  logic [2:0]        rf_waddr_q, rf_waddr_d;
  logic [31:0]       rf_wdata_q, rf_wdata_d;
  logic              br_taken_q, br_taken_d;
  logic [PC_W-1:0]   br_target_q, br_target_d;
  logic              illegal_q, illegal_d;
  logic              halt_q, halt_d;

  logic [29:0]       cur;
  logic [4:0]        f_opc;
  logic [2:0]        f_dst, f_src0, f_src1;
  logic [15:0]       f_imm;
  logic [31:0]       imm_zx;
  logic              unused_inst_bits;

  assign unused_inst_bits = ^inst[31:30];

  // Register addresses come straight off the input while idle so the synchronous read
  // returns data in READ; afterwards they follow the latched instruction.
  assign cur    = (state_q == IDLE) ? inst[29:0] : inst_q;
  assign f_opc  = cur[29:25];
  assign f_dst  = cur[24:22];
  assign f_src0 = cur[21:19];
  assign f_src1 = cur[18:16];
  assign f_imm  = cur[15:0];
  assign imm_zx = {16'h0000, f_imm};

  assign inst_ready = (state_q == IDLE) && !halt_q;
  assign rf_raddr0  = (f_opc == OP_LHI) ? f_dst : f_src0;
  assign rf_raddr1  = f_src1;

  function automatic logic [31:0] operand(input logic [2:0] sel, input logic [31:0] rdata,
                                          input logic [15:0] imm);
    if (sel == 3'd0)      return 32'h0;
    else if (sel == 3'd1) return {{16{imm[15]}}, imm};
    else                  return rdata;
  endfunction

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    pc_d        = pc_q;
    opc_d       = opc_q;
    alu0_d      = alu0_q;
    alu1_d      = alu1_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    br_taken_d  = 1'b0;
    br_target_d = br_target_q;
    illegal_d   = 1'b0;
    halt_d      = halt_q;
    case (state_q)
      IDLE: begin
        if (inst_valid && inst_ready) begin
          inst_d  = inst[29:0];
          pc_d    = inst_pc;
          state_d = READ;
        end
      end
      READ: begin
        opc_d = f_opc;
        if (f_opc == OP_LHI) begin
          alu0_d = operand(f_dst, rf_rdata0, f_imm);
          alu1_d = imm_zx;
        end else begin
          alu0_d = operand(f_src0, rf_rdata0, f_imm);
          alu1_d = operand(f_src1, rf_rdata1, f_imm);
        end
        state_d = EXEC;
      end
      EXEC: begin
        // The WB strobes are registered here, so the write-data register doubles as
        // the captured ALU result.
        if (f_opc[4:3] == 2'b00) begin
          rf_we_d    = (f_dst > 3'd1);
          rf_waddr_d = f_dst;
          rf_wdata_d = aluout;
        end else if (f_opc inside {OP_JLT, OP_JLE, OP_JEQ, OP_JNE, OP_JIN}) begin
          if (f_opc == OP_JIN || aluout == 32'd1) begin
            br_taken_d  = 1'b1;
            br_target_d = (f_opc == OP_JIN) ? alu0_q[PC_W-1:0] : imm_zx[PC_W-1:0];
            rf_we_d     = 1'b1;
            rf_waddr_d  = 3'd7;
            rf_wdata_d  = 32'(pc_q);
          end
        end else if (f_opc == OP_HLT) begin
          halt_d = 1'b1;
        end else begin
          illegal_d = 1'b1;
          if (HALT_ON_ILLEGAL) halt_d = 1'b1;
        end
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      inst_q      <= '0;
      pc_q        <= '0;
      opc_q       <= '0;
      alu0_q      <= '0;
      alu1_q      <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      illegal_q   <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      inst_q      <= inst_d;
      pc_q        <= pc_d;
      opc_q       <= opc_d;
      alu0_q      <= alu0_d;
      alu1_q      <= alu1_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      illegal_q   <= illegal_d;
      halt_q      <= halt_d;
    end
  end

  assign alu_opcode = opc_q;
  assign alu0       = alu0_q;
  assign alu1       = alu1_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign br_taken   = br_taken_q;
  assign br_target  = br_target_q;
  assign illegal    = illegal_q;
  assign halt       = halt_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: register file and ALU models around the DUT, directed instructions,
// and a scoreboard of expected writeback/branch/illegal strobes.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic [2:0]  rf_raddr0, rf_raddr1;
  logic [31:0] rf_rdata0, rf_rdata1;
  logic [4:0]  alu_opcode;
  logic [31:0] alu0, alu1, aluout;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        br_taken;
  logic [15:0] br_target;
  logic        illegal;
  logic        halt;

  alu_issue #(.PC_W(16), .HALT_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
    .alu_opcode(alu_opcode), .alu0(alu0), .alu1(alu1), .aluout(aluout),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .br_taken(br_taken), .br_target(br_target), .illegal(illegal), .halt(halt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file with synchronous read; the bench preloads it through the poke port.
  logic [31:0] rf [8];
  logic        poke_en = 1'b0;
  logic [2:0]  poke_a  = 3'd0;
  logic [31:0] poke_d  = 32'd0;
  always @(posedge clk) begin
    if (poke_en)    rf[poke_a] <= poke_d;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
    rf_rdata0 <= rf[rf_raddr0];
    rf_rdata1 <= rf[rf_raddr1];
  end

  // Behavioural ALU: jumps return 1 when the condition holds.
  always_comb begin
    aluout = 32'd0;
    case (alu_opcode)
      5'd0:  aluout = alu0 + alu1;
      5'd1:  aluout = alu0 - alu1;
      5'd2:  aluout = alu0 << alu1[4:0];
      5'd3:  aluout = alu0 >> alu1[4:0];
      5'd4:  aluout = alu0 & alu1;
      5'd5:  aluout = alu0 | alu1;
      5'd6:  aluout = alu0 ^ alu1;
      5'd7:  aluout = {alu1[15:0], alu0[15:0]};
      5'd16: aluout = {31'd0, $signed(alu0) <  $signed(alu1)};
      5'd17: aluout = {31'd0, $signed(alu0) <= $signed(alu1)};
      5'd18: aluout = {31'd0, alu0 == alu1};
      5'd19: aluout = {31'd0, alu0 != alu1};
      5'd20: aluout = 32'd1;
      default: aluout = 32'd0;
    endcase
  end

  typedef struct {
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        bt;
    logic [15:0] tg;
    logic        il;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t mkexp(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                                 input logic bt, input logic [15:0] tg, input logic il);
    exp_t e;
    e.we = we; e.wa = wa; e.wd = wd; e.bt = bt; e.tg = tg; e.il = il; e.cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] d,
                                     input logic [2:0] s0, input logic [2:0] s1,
                                     input logic [15:0] imm);
    return {2'b00, opc, d, s0, s1, imm};
  endfunction

  // Monitor: every WB strobe must match the oldest expectation, in the expected cycle.
  always @(negedge clk) begin
    if (reset === 1'b1 && (rf_we || br_taken || illegal)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_strobe: got we=%b bt=%b il=%b expected none (cycle %0d)",
                 rf_we, br_taken, illegal, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wb_cycle", cyc, e.cyc);
        chk("rf_we", {31'd0, rf_we}, {31'd0, e.we});
        chk("br_taken", {31'd0, br_taken}, {31'd0, e.bt});
        chk("illegal", {31'd0, illegal}, {31'd0, e.il});
        if (e.we) begin
          chk("rf_waddr", {29'd0, rf_waddr}, {29'd0, e.wa});
          chk("rf_wdata", rf_wdata, e.wd);
        end
        if (e.bt) chk("br_target", {16'd0, br_target}, {16'd0, e.tg});
      end
    end
  end

  task automatic poke(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_a = a; poke_d = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of cycle 4 after acceptance.
  task automatic send(input string nm, input logic [31:0] iw, input logic [15:0] pc,
                      input logic [4:0] eo, input logic [31:0] ea0, input logic [31:0] ea1,
                      input bit has_wb, input exp_t e);
    int budget;
    inst_valid = 1'b1; inst = iw; inst_pc = pc;
    budget = 0;
    while (!inst_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!inst_ready) begin
      chk({nm, "_accept"}, {31'd0, inst_ready}, 32'd1);
      inst_valid = 1'b0;
      return;
    end
    e.cyc = cyc + 3;
    if (has_wb) sb.push_back(e);
    @(negedge clk);
    inst_valid = 1'b0;
    chk({nm, "_ready_c1"}, {31'd0, inst_ready}, 32'd0);
    @(negedge clk);
    chk({nm, "_opcode"}, {27'd0, alu_opcode}, {27'd0, eo});
    chk({nm, "_alu0"}, alu0, ea0);
    chk({nm, "_alu1"}, alu1, ea1);
    chk({nm, "_ready_c2"}, {31'd0, inst_ready}, 32'd0);
    @(negedge clk);
    chk({nm, "_ready_c3"}, {31'd0, inst_ready}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    none = mkexp(1'b0, 3'd0, 32'd0, 1'b0, 16'd0, 1'b0);
    reset = 1'b0; inst_valid = 1'b0; inst = 32'd0; inst_pc = 16'd0;

    poke(3'd3, 32'd5);
    poke(3'd4, 32'd7);
    poke(3'd6, 32'hAAAA5678);
    @(negedge clk);
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_alu0", alu0, 32'd0);
    chk("rst_br_target", {16'd0, br_target}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, inst_ready}, 32'd1);

    send("add", mk(5'd0, 3'd2, 3'd3, 3'd4, 16'd0), 16'd0, 5'd0, 32'd5, 32'd7,
         1'b1, mkexp(1'b1, 3'd2, 32'd12, 1'b0, 16'd0, 1'b0));
    send("sub", mk(5'd1, 3'd5, 3'd1, 3'd0, 16'hFFFE), 16'd0, 5'd1, 32'hFFFFFFFE, 32'd0,
         1'b1, mkexp(1'b1, 3'd5, 32'hFFFFFFFE, 1'b0, 16'd0, 1'b0));
    send("add_r1", mk(5'd0, 3'd1, 3'd3, 3'd4, 16'd0), 16'd0, 5'd0, 32'd5, 32'd7, 1'b0, none);
    send("lhi", mk(5'd7, 3'd6, 3'd0, 3'd0, 16'h1234), 16'd0, 5'd7, 32'hAAAA5678, 32'h1234,
         1'b1, mkexp(1'b1, 3'd6, 32'h12345678, 1'b0, 16'd0, 1'b0));

    poke(3'd3, 32'd9);
    poke(3'd4, 32'd9);
    @(negedge clk);
    send("jeq", mk(5'd18, 3'd0, 3'd3, 3'd4, 16'h0040), 16'h0010, 5'd18, 32'd9, 32'd9,
         1'b1, mkexp(1'b1, 3'd7, 32'h10, 1'b1, 16'h0040, 1'b0));
    send("jne", mk(5'd19, 3'd0, 3'd3, 3'd4, 16'h0040), 16'h0014, 5'd19, 32'd9, 32'd9, 1'b0, none);
    send("jin", mk(5'd20, 3'd0, 3'd3, 3'd4, 16'h0077), 16'h0022, 5'd20, 32'd9, 32'd9,
         1'b1, mkexp(1'b1, 3'd7, 32'h22, 1'b1, 16'h0009, 1'b0));
    send("ill8", mk(5'd8, 3'd2, 3'd3, 3'd4, 16'd0), 16'd0, 5'd8, 32'd9, 32'd9,
         1'b1, mkexp(1'b0, 3'd0, 32'd0, 1'b0, 16'd0, 1'b1));
    chk("ill_no_halt", {31'd0, halt}, 32'd0);

    send("hlt", mk(5'd24, 3'd0, 3'd0, 3'd0, 16'd0), 16'd0, 5'd24, 32'd0, 32'd0, 1'b0, none);
    chk("halt_set", {31'd0, halt}, 32'd1);
    inst_valid = 1'b1; inst = mk(5'd0, 3'd2, 3'd3, 3'd4, 16'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("halt_ready", {31'd0, inst_ready}, 32'd0);
    end
    inst_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("halt_cleared", {31'd0, halt}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, inst_ready}, 32'd1);

    // Abort an ADD r2 in EXEC: nothing may be written back.
    inst_valid = 1'b1; inst = mk(5'd0, 3'd2, 3'd3, 3'd4, 16'd0); inst_pc = 16'd0;
    @(negedge clk);
    inst_valid = 1'b0;
    @(negedge clk);
    chk("abort_alu0", alu0, 32'd9);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rf_we", {31'd0, rf_we}, 32'd0);
    chk("abort_alu0_clr", alu0, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    chk("abort_ready", {31'd0, inst_ready}, 32'd1);

    send("add_after", mk(5'd0, 3'd2, 3'd3, 3'd4, 16'd0), 16'd0, 5'd0, 32'd9, 32'd9,
         1'b1, mkexp(1'b1, 3'd2, 32'd18, 1'b0, 16'd0, 1'b0));
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
